calendar_date: RTL and testbench

Day-of-month / month / year counter that sits directly upstream of the day-of-week counter. It consumes the one-cycle day-rollover tick from the hour counter and advances the calendar date, handling month lengths and leap years. On every date advance it emits a one-cycle dow_adv pulse that drives the enable/advance input of the day-of-week counter, so both stay in lock-step. It also supports validated parallel load for date setting.

---
 rtl/calendar_date.sv | 164 ++++++++++++++++
 tb/tb_calendar_date.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_date.sv
// ============================================================================
// Module   : calendar_date
// Brief    : Day/month/year counter (2000..2099) with validated load and a
//            dow_adv pulse for the day-of-week counter. Optional BCD outputs
//            are enabled with the CAL_BCD_OUT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calendar_date #(
    parameter int YEAR_W    = 7,
    parameter int RST_DATE  = 1,
    parameter int RST_MONTH = 1,
    parameter int RST_YEAR  = 0
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              tick_in,
    input  logic              load,
    input  logic [4:0]        load_date,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    output logic [4:0]        date,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              leap,
    output logic              dow_adv,
    output logic              year_wrap,
    output logic              load_err
`ifdef CAL_BCD_OUT_EN
    ,
    output logic [7:0]        date_bcd,
    output logic [7:0]        month_bcd,
    output logic [7:0]        year_bcd
`endif
);

    localparam logic [YEAR_W-1:0] c_YEAR_MAX = YEAR_W'(99);

    logic [4:0]        r_date;
    logic [3:0]        r_month;
    logic [YEAR_W-1:0] r_year;
    logic              r_dow_adv;
    logic              r_year_wrap;
    logic              r_load_err;

    logic [4:0]        w_nxt_date;
    logic [3:0]        w_nxt_month;
    logic [YEAR_W-1:0] w_nxt_year;
    logic              w_nxt_dow_adv;
    logic              w_nxt_year_wrap;
    logic              w_nxt_load_err;
    logic              w_leap;
    logic              w_load_ok;

    // Out-of-range months fall into the 31-day default so a corrupted month
    // still rolls over cleanly on the next tick.
    function automatic logic [4:0] last_day(input logic [3:0] m, input logic lp);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: last_day = 5'd30;
            4'd2:                    last_day = lp ? 5'd29 : 5'd28;
            default:                 last_day = 5'd31;
        endcase
    endfunction

    assign w_leap = (r_year[1:0] == 2'b00);

    assign w_load_ok = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                       (load_year <= c_YEAR_MAX) && (load_date != 5'd0) &&
                       (load_date <= last_day(load_month, load_year[1:0] == 2'b00));

    always_comb begin
        w_nxt_date      = r_date;
        w_nxt_month     = r_month;
        w_nxt_year      = r_year;
        w_nxt_dow_adv   = 1'b0;
        w_nxt_year_wrap = 1'b0;
        w_nxt_load_err  = 1'b0;
        if (load) begin
            // A coincident tick is deliberately dropped here.
            if (w_load_ok) begin
                w_nxt_date  = load_date;
                w_nxt_month = load_month;
                w_nxt_year  = load_year;
            end else begin
                w_nxt_load_err = 1'b1;
            end
        end else if (tick_in) begin
            w_nxt_dow_adv = 1'b1;
            if (r_date < last_day(r_month, w_leap)) begin
                w_nxt_date = r_date + 5'd1;
            end else begin
                w_nxt_date = 5'd1;
                if (r_month < 4'd12) begin
                    w_nxt_month = r_month + 4'd1;
                end else begin
                    w_nxt_month = 4'd1;
                    if (r_year < c_YEAR_MAX) begin
                        w_nxt_year = r_year + YEAR_W'(1);
                    end else begin
                        w_nxt_year      = '0;
                        w_nxt_year_wrap = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_date      <= 5'(RST_DATE);
            r_month     <= 4'(RST_MONTH);
            r_year      <= YEAR_W'(RST_YEAR);
            r_dow_adv   <= 1'b0;
            r_year_wrap <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_date      <= w_nxt_date;
            r_month     <= w_nxt_month;
            r_year      <= w_nxt_year;
            r_dow_adv   <= w_nxt_dow_adv;
            r_year_wrap <= w_nxt_year_wrap;
            r_load_err  <= w_nxt_load_err;
        end
    end

    assign date      = r_date;
    assign month     = r_month;
    assign year      = r_year;
    assign leap      = w_leap;
    assign dow_adv   = r_dow_adv;
    assign year_wrap = r_year_wrap;
    assign load_err  = r_load_err;

`ifdef CAL_BCD_OUT_EN
    logic [7:0] r_date_bcd;
    logic [7:0] r_month_bcd;
    logic [7:0] r_year_bcd;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        to_bcd = {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Converted from the next-state values so BCD and binary change together.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_date_bcd  <= to_bcd(7'(RST_DATE));
            r_month_bcd <= to_bcd(7'(RST_MONTH));
            r_year_bcd  <= to_bcd(7'(RST_YEAR));
        end else begin
            r_date_bcd  <= to_bcd({2'b00, w_nxt_date});
            r_month_bcd <= to_bcd({3'b000, w_nxt_month});
            r_year_bcd  <= to_bcd(7'(w_nxt_year));
        end
    end

    assign date_bcd  = r_date_bcd;
    assign month_bcd = r_month_bcd;
    assign year_bcd  = r_year_bcd;
`endif

endmodule

`default_nettype wire

// File: tb/tb_calendar_date.sv
// ============================================================================
// Module   : tb_calendar_date
// Brief    : Directed plus randomized bench for calendar_date; the reference
//            works on a linear day number since 2000-01-01.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calendar_date;

    logic       clk = 1'b0;
    logic       clear, tick_in, load;
    logic [4:0] load_date;
    logic [3:0] load_month;
    logic [6:0] load_year;
    logic [4:0] date;
    logic [3:0] month;
    logic [6:0] year;
    logic       leap, dow_adv, year_wrap, load_err;
`ifdef CAL_BCD_OUT_EN
    logic [7:0] date_bcd, month_bcd, year_bcd;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state and the pulses expected after the current step
    int md, mm, my;
    int e_dow, e_wrap, e_err;

    calendar_date #(.YEAR_W(7), .RST_DATE(1), .RST_MONTH(1), .RST_YEAR(0)) dut (
        .clk        (clk),
        .clear      (clear),
        .tick_in    (tick_in),
        .load       (load),
        .load_date  (load_date),
        .load_month (load_month),
        .load_year  (load_year),
        .date       (date),
        .month      (month),
        .year       (year),
        .leap       (leap),
        .dow_adv    (dow_adv),
        .year_wrap  (year_wrap),
        .load_err   (load_err)
`ifdef CAL_BCD_OUT_EN
        ,
        .date_bcd   (date_bcd),
        .month_bcd  (month_bcd),
        .year_bcd   (year_bcd)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic int mlen(input int m, input int y);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && (y % 4) == 0) return 29;
        return t[m-1];
    endfunction

    function automatic int to_days(input int d, input int m, input int y);
        int n = d - 1;
        for (int i = 0; i < y; i++) n += ((i % 4) == 0) ? 366 : 365;
        for (int i = 1; i < m; i++) n += mlen(i, y);
        return n;
    endfunction

    task automatic from_days(input int n, output int d, output int m, output int y);
        y = 0;
        while (n >= (((y % 4) == 0) ? 366 : 365)) begin
            n -= ((y % 4) == 0) ? 366 : 365;
            y++;
        end
        m = 1;
        while (n >= mlen(m, y)) begin
            n -= mlen(m, y);
            m++;
        end
        d = n + 1;
    endtask

    function automatic bit valid(input int d, input int m, input int y);
        if (m < 1 || m > 12 || y > 99 || d < 1) return 1'b0;
        return d <= mlen(m, y);
    endfunction

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit c, input bit t, input bit l, input int ld, input int lm, input int ly);
        int n;
        e_dow = 0; e_wrap = 0; e_err = 0;
        if (c) begin
            md = 1; mm = 1; my = 0;
        end else if (l) begin
            if (valid(ld, lm, ly)) begin
                md = ld; mm = lm; my = ly;
            end else begin
                e_err = 1;
            end
        end else if (t) begin
            e_dow = 1;
            n = to_days(md, mm, my) + 1;
            if (n == 36525) begin
                n = 0;
                e_wrap = 1;
            end
            from_days(n, md, mm, my);
        end
    endtask

    task automatic step(input bit c, input bit t, input bit l, input int ld, input int lm, input int ly);
        clear      = c;
        tick_in    = t;
        load       = l;
        load_date  = 5'(ld);
        load_month = 4'(lm);
        load_year  = 7'(ly);
        model(c, t, l, ld, lm, ly);
        @(posedge clk);
        #1;
        clear = 1'b0; tick_in = 1'b0; load = 1'b0;
        chk("date",      32'(date),      32'(md));
        chk("month",     32'(month),     32'(mm));
        chk("year",      32'(year),      32'(my));
        chk("leap",      32'(leap),      32'((my % 4) == 0));
        chk("dow_adv",   32'(dow_adv),   32'(e_dow));
        chk("year_wrap", 32'(year_wrap), 32'(e_wrap));
        chk("load_err",  32'(load_err),  32'(e_err));
`ifdef CAL_BCD_OUT_EN
        chk("date_bcd",  32'(date_bcd),  32'(bcd(md)));
        chk("month_bcd", 32'(month_bcd), 32'(bcd(mm)));
        chk("year_bcd",  32'(year_bcd),  32'(bcd(my)));
`endif
    endtask

    initial begin
        int cnt;
        clear = 1'b0; tick_in = 1'b0; load = 1'b0;
        load_date = '0; load_month = '0; load_year = '0;
        md = 1; mm = 1; my = 0;
        @(posedge clk); #1;

        // Reset
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Month-end and year-end rollover
        step(0, 0, 1, 31, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 31, 12, 99);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Leap handling
        step(0, 0, 1, 28, 2, 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 28, 2, 4);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        // Load validation
        step(0, 0, 1, 30, 2, 4);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 29, 2, 3);
        step(0, 0, 1, 0, 5, 10);
        step(0, 0, 1, 10, 13, 10);
        step(0, 0, 1, 5, 5, 100);
        step(0, 0, 1, 30, 4, 10);
        step(0, 0, 1, 31, 4, 10);

        // Collisions
        step(0, 1, 1, 15, 6, 20);
        step(0, 1, 1, 31, 6, 20);
        step(1, 1, 0, 0, 0, 0);

        // 40 consecutive ticks from 01/01/00
        step(0, 0, 1, 1, 1, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0, 0, 0, 0);
            if (dow_adv === 1'b1) cnt++;
        end
        chk("dow_adv_count", 32'(cnt), 32'd40);
        chk("tick40_date",   32'(date),  32'd10);
        chk("tick40_month",  32'(month), 32'd2);

`ifdef CAL_BCD_OUT_EN
        step(0, 0, 1, 29, 12, 47);
        step(0, 1, 0, 0, 0, 0);
`endif

        // Randomized traffic, with occasional near-boundary loads
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 55)
                step(0, 1, 0, 0, 0, 0);
            else if (r < 65)
                step(0, 0, 0, 0, 0, 0);
            else if (r < 75)
                step(0, 0, 1, int'($urandom_range(27, 31)), int'($urandom_range(1, 12)),
                     (($urandom_range(0, 3) == 0) ? 99 : int'($urandom_range(0, 99))));
            else if (r < 95)
                step(0, int'($urandom_range(0, 1)), 1, int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 110)));
            else
                step(int'($urandom_range(0, 1)), 1, 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
